// File: rtl/alu_pkg.sv
// Shared opcode encodings and widths for the ALU and its issue stage.
package alu_pkg;

    localparam int unsigned ALU_W   = 16;
    localparam int unsigned ALU_OPW = 3;

    localparam logic [ALU_OPW-1:0] OP_AND  = 3'b000;
    localparam logic [ALU_OPW-1:0] OP_OR   = 3'b001;
    localparam logic [ALU_OPW-1:0] OP_XOR  = 3'b010;
    localparam logic [ALU_OPW-1:0] OP_XNOR = 3'b011;
    localparam logic [ALU_OPW-1:0] OP_ADD  = 3'b100;
    localparam logic [ALU_OPW-1:0] OP_SUB  = 3'b101;
    localparam logic [ALU_OPW-1:0] OP_MUL  = 3'b110;
    localparam logic [ALU_OPW-1:0] OP_DIV  = 3'b111;

endpackage

// File: rtl/alu_operand_fifo.sv
// Small synchronous FIFO holding {a,b,op} operand packets ahead of the ALU.
module alu_operand_fifo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned OPW   = ALU_OPW,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_a,
    input  logic [WIDTH-1:0]             push_b,
    input  logic [OPW-1:0]               push_op,
    output logic [WIDTH-1:0]             head_a,
    output logic [WIDTH-1:0]             head_b,
    output logic [OPW-1:0]               head_op,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] a_q  [DEPTH];
    logic [WIDTH-1:0] b_q  [DEPTH];
    logic [OPW-1:0]   op_q [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en_c;
    logic          pop_en_c;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_a  = a_q[rptr_q];
    assign head_b  = b_q[rptr_q];
    assign head_op = op_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        push_en_c = push && !full;
        pop_en_c  = pop && !empty;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (push_en_c) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_en_c) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_en_c, pop_en_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                a_q[i]  <= '0;
                b_q[i]  <= '0;
                op_q[i] <= '0;
            end
        end else if (push_en_c) begin
            a_q[wptr_q]  <= push_a;
            b_q[wptr_q]  <= push_b;
            op_q[wptr_q] <= push_op;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding an external combinational ALU and registering its result.
// Optional feature: define ALU_DIV0_FLAG_EN to saturate and flag divide-by-zero results.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned OPW   = ALU_OPW,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [OPW-1:0]   res_op,
    output logic             res_zero,
    output logic             res_div0
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [OPW-1:0]   head_op;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push_c;
    logic             cap_c;

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic [OPW-1:0]   res_op_q,    res_op_d;
    logic             res_zero_q,  res_zero_d;

    assign push_c = in_valid && !full;
    assign cap_c  = (count != '0) && (!res_valid_q || res_ready);

    alu_operand_fifo #(
        .WIDTH (WIDTH),
        .OPW   (OPW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (cap_c),
        .push_a  (in_a),
        .push_b  (in_b),
        .push_op (in_op),
        .head_a  (head_a),
        .head_b  (head_b),
        .head_op (head_op),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // The ALU sees all-zero operands whenever nothing is queued.
    assign in_ready = !full;
    assign alu_a    = empty ? '0 : head_a;
    assign alu_b    = empty ? '0 : head_b;
    assign alu_op   = empty ? '0 : head_op;

`ifdef ALU_DIV0_FLAG_EN
    logic res_div0_q, res_div0_d;
    logic div0_c;

    assign div0_c = (head_op == OPW'(OP_DIV)) && (head_b == '0);
`endif

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_zero_d  = res_zero_q;
`ifdef ALU_DIV0_FLAG_EN
        res_div0_d  = res_div0_q;
`endif
        if (cap_c) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_out;
            res_op_d    = head_op;
            res_zero_d  = (alu_out == '0);
`ifdef ALU_DIV0_FLAG_EN
            res_div0_d  = 1'b0;
            if (div0_c) begin
                res_data_d = '1;
                res_zero_d = 1'b0;
                res_div0_d = 1'b1;
            end
`endif
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_zero_q  <= res_zero_d;
        end
    end

`ifdef ALU_DIV0_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_div0_q <= 1'b0;
        end else begin
            res_div0_q <= res_div0_d;
        end
    end

    assign res_div0 = res_div0_q;
`else
    assign res_div0 = 1'b0;
`endif

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_zero  = res_zero_q;

endmodule
